// File: rtl/fcvt_pkg.sv
// Shared FP32 field constants, id-width helper and result FIFO entry type
// for the int-to-float conversion scheduler.
package fcvt_pkg;

  localparam int BIAS    = 127;
  localparam int EXP_W   = 8;
  localparam int FRAC_W  = 23;
  localparam int ID_MAXW = 3;

  localparam logic [31:0] FP32_ZERO = 32'h0000_0000;

  function automatic int id_w(input int n);
    return $clog2(n);
  endfunction

  typedef struct packed {
    logic [31:0]        res;
    logic [ID_MAXW-1:0] id;
  } fcvt_entry_t;

endpackage

// File: rtl/fcvt_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above the pointer,
// wrapping; the pointer moves just past the winner on every grant.
module fcvt_rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         en,
  output logic [N-1:0] gnt
);

  localparam int PW = $clog2(N);

  logic [PW-1:0] ptr;
  logic [PW-1:0] gidx;
  logic [PW-1:0] j;
  logic          hit;

  always_comb begin
    gnt  = '0;
    gidx = '0;
    hit  = 1'b0;
    j    = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = PW'((32'(ptr) + k) % N);
      if (en && !hit && req[j]) begin
        hit    = 1'b1;
        gnt[j] = 1'b1;
        gidx   = j;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)    ptr <= '0;
    else if (hit) ptr <= PW'((32'(gidx) + 1) % N);
  end

endmodule

// File: rtl/fcvt_sched.sv
// Shared int-to-float converter: round-robin issue, 2-stage pipeline and a
// credit-protected show-ahead result FIFO. FCVT_SCHED_PERF_EN adds perf counters.
module fcvt_sched
  import fcvt_pkg::*;
#(
  parameter int N_REQ      = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*32-1:0]     req_data,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [id_w(N_REQ)-1:0]  rsp_id,
  output logic                    busy
`ifdef FCVT_SCHED_PERF_EN
  ,
  output logic [31:0]             perf_issue,
  output logic [31:0]             perf_stall
`endif
);

  localparam int IDW = id_w(N_REQ);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int PW  = $clog2(FIFO_DEPTH);

  logic [CW-1:0]      cnt, fcnt;
  logic               issue_en, accept, pop;
  logic [ID_MAXW-1:0] acc_id;
  logic [31:0]        acc_op;

  logic               s1_v, s2_v;
  logic [31:0]        s1_op;
  logic [ID_MAXW-1:0] s1_id;
  fcvt_entry_t        s2_e;

  logic [31:0]        mag, norm, conv;
  logic [4:0]         lead;

  fcvt_entry_t        mem [FIFO_DEPTH];
  logic [PW-1:0]      wp, rp;
  fcvt_entry_t        head;

  // Credit check covers every in-flight conversion, so S1/S2 never stall.
  assign issue_en = rstn && (cnt < CW'(FIFO_DEPTH));

  fcvt_rr_arb #(.N(N_REQ)) u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  (req_valid),
    .en   (issue_en),
    .gnt  (req_ready)
  );

  assign accept = |req_ready;
  assign pop    = rsp_valid & rsp_ready;
  assign busy   = (cnt != '0);

  always_comb begin
    acc_id = '0;
    acc_op = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        acc_id = ID_MAXW'(i);
        acc_op = req_data[32*i +: 32];
      end
    end
  end

  always_comb begin
    mag  = s1_op[31] ? (~s1_op + 32'd1) : s1_op;
    lead = '0;
    for (int unsigned b = 0; b < 32; b++) begin
      if (mag[b]) lead = 5'(b);
    end
    norm = mag << (5'd31 - lead);
    conv = (s1_op == '0) ? FP32_ZERO
         : {s1_op[31], EXP_W'(BIAS) + {3'b000, lead}, FRAC_W'(norm >> 8)};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_v  <= 1'b0;
      s1_op <= '0;
      s1_id <= '0;
      s2_v  <= 1'b0;
      s2_e  <= '0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_op <= acc_op;
        s1_id <= acc_id;
      end
      s2_v <= s1_v;
      if (s1_v) s2_e <= '{res: conv, id: s1_id};
    end
  end

  always_ff @(posedge clk) begin
    if (s2_v) mem[wp] <= s2_e;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wp   <= '0;
      rp   <= '0;
      fcnt <= '0;
      cnt  <= '0;
    end else begin
      if (s2_v) wp <= (wp == PW'(FIFO_DEPTH - 1)) ? '0 : wp + 1'b1;
      if (pop)  rp <= (rp == PW'(FIFO_DEPTH - 1)) ? '0 : rp + 1'b1;
      if (s2_v && !pop)      fcnt <= fcnt + 1'b1;
      else if (!s2_v && pop) fcnt <= fcnt - 1'b1;
      if (accept && !pop)      cnt <= cnt + 1'b1;
      else if (!accept && pop) cnt <= cnt - 1'b1;
    end
  end

  assign head      = mem[rp];
  assign rsp_valid = (fcnt != '0);
  assign rsp_data  = rsp_valid ? head.res : FP32_ZERO;
  assign rsp_id    = rsp_valid ? IDW'(head.id) : '0;

`ifdef FCVT_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_issue <= '0;
      perf_stall <= '0;
    end else begin
      if (accept) perf_issue <= perf_issue + 32'd1;
      if ((|req_valid) && (cnt == CW'(FIFO_DEPTH))) perf_stall <= perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fcvt_sched.sv
// Self-checking bench for fcvt_sched: directed scenarios plus random traffic
// against an order/latency/arithmetic reference model.
module tb_fcvt_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  rv;
  logic [1:0]  req_ready;
  logic [63:0] rd;
  logic        rsp_valid;
  logic        rr;
  logic [31:0] rsp_data;
  logic        rsp_id;
  logic        busy;
`ifdef FCVT_SCHED_PERF_EN
  logic [31:0] perf_issue, perf_stall;
`endif

  fcvt_sched #(.N_REQ(2), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (rv),
    .req_ready (req_ready),
    .req_data  (rd),
    .rsp_valid (rsp_valid),
    .rsp_ready (rr),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .busy      (busy)
`ifdef FCVT_SCHED_PERF_EN
    ,
    .perf_issue(perf_issue),
    .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          id;
    int          rdy;
  } exp_t;

  exp_t        q[$];
  logic [31:0] seen_d[$];
  int          seen_id[$];
  int          m_ptr, m_cnt, cyc, m_issue, m_stall;
  logic [1:0]  acc_mask, obs_rdy;
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [31:0] ref_conv(input logic [31:0] x);
    longint m, f;
    int     e;
    if (x == 32'h0) return 32'h0;
    m = x[31] ? (longint'(64'h1_0000_0000) - longint'(x)) : longint'(x);
    e = 0;
    while ((m >> (e + 1)) != 0) e++;
    f = m - (longint'(1) << e);
    if (e > 23) f = f >> (e - 23);
    else        f = f << (23 - e);
    return {x[31], 8'(127 + e), f[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [31:0] x;
    case ($urandom_range(0, 3))
      0:       x = $urandom_range(0, 15);
      1:       x = 32'h0 - 32'($urandom_range(1, 300));
      default: x = $urandom;
    endcase
    if (x == 32'h8000_0000) x = 32'h1;
    return x;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ptr = 0; m_cnt = 0; m_issue = 0; m_stall = 0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cycle();
    int   g;
    logic ev, pop;
    logic [1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    if (rstn && m_cnt < 4) begin
      for (int k = 0; k < 2; k++) begin
        if (g < 0 && rv[(m_ptr + k) % 2]) g = (m_ptr + k) % 2;
      end
    end
    exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
    obs_rdy = req_ready;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    ev = (q.size() > 0) && (q[0].rdy <= cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    if (ev) begin
      chk("rsp_data", rsp_data, q[0].d);
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
    end
    chk("busy", 32'(busy), 32'(m_cnt != 0));
`ifdef FCVT_SCHED_PERF_EN
    chk("perf_issue", perf_issue, 32'(m_issue));
    chk("perf_stall", perf_stall, 32'(m_stall));
`endif
    pop = ev && rr;
    if (pop) begin
      seen_d.push_back(rsp_data);
      seen_id.push_back(int'(rsp_id));
    end
    if (rstn && (|rv) && m_cnt == 4) m_stall++;
    @(posedge clk);
    acc_mask = exp_rdy;
    if (g >= 0) begin
      q.push_back('{d: ref_conv(rd[32*g +: 32]), id: g, rdy: cyc + 3});
      m_ptr = (g + 1) % 2;
      m_issue++;
    end
    if (pop) void'(q.pop_front());
    m_cnt = m_cnt + ((g >= 0) ? 1 : 0) - (pop ? 1 : 0);
    cyc++;
    #1;
  endtask

  task automatic issue(input int i, input logic [31:0] d);
    bit got = 1'b0;
    rv[i] = 1'b1;
    rd[32*i +: 32] = d;
    for (int n = 0; n < 20 && !got; n++) begin
      cycle();
      if (acc_mask[i]) got = 1'b1;
    end
    rv[i] = 1'b0;
    chk("issue_granted", 32'(got), 32'd1);
  endtask

  task automatic drain();
    rv = 2'b00;
    rr = 1'b1;
    for (int n = 0; n < 40 && (q.size() != 0 || m_cnt != 0); n++) cycle();
    chk("drained", 32'(q.size() == 0 && m_cnt == 0), 32'd1);
  endtask

  initial begin
    int acc_n;
    logic [31:0] dir_d[3];
    dir_d[0] = 32'hBF80_0000;
    dir_d[1] = 32'h4B80_0000;
    dir_d[2] = 32'h0000_0000;
    rstn = 1'b0; rv = 2'b00; rd = '0; rr = 1'b0;
    cyc = 0;
    model_reset();

    // Reset state
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // Single request, requester 0
    rr = 1'b1;
    seen_d.delete(); seen_id.delete();
    issue(0, 32'h0000_0005);
    drain();
    chk("single_count", 32'(seen_d.size()), 32'd1);
    if (seen_d.size() == 1) begin
      chk("single_data", seen_d[0], 32'h40A0_0000);
      chk("single_id", 32'(seen_id[0]), 32'd0);
    end

    // Requester 1 sequence: -1, truncation case, zero
    seen_d.delete(); seen_id.delete();
    issue(1, 32'hFFFF_FFFF);
    issue(1, 32'h0100_0001);
    issue(1, 32'h0000_0000);
    drain();
    chk("seq_count", 32'(seen_d.size()), 32'd3);
    for (int k = 0; k < 3 && k < seen_d.size(); k++) begin
      chk("seq_data", seen_d[k], dir_d[k]);
      chk("seq_id", 32'(seen_id[k]), 32'd1);
    end

    // Both requesting: strict alternation, one issue every cycle
    seen_d.delete(); seen_id.delete();
    rr = 1'b1; rv = 2'b11;
    rd = {rnd_op(), rnd_op()};
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("alt_grant", 32'(obs_rdy), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (acc_mask[0]) rd[31:0]  = rnd_op();
      if (acc_mask[1]) rd[63:32] = rnd_op();
    end
    drain();
    chk("alt_count", 32'(seen_d.size()), 32'd8);
    for (int k = 0; k < 8 && k < seen_id.size(); k++)
      chk("alt_id", 32'(seen_id[k]), 32'(k % 2));

    // Credit stall, then drain and resume
    model_reset();
    rstn = 1'b0;
    #1 rstn = 1'b1;
    rr = 1'b0; rv = 2'b11;
    rd = {rnd_op(), rnd_op()};
    acc_n = 0;
    for (int k = 0; k < 10; k++) begin
      cycle();
      if (obs_rdy != 2'b00) acc_n++;
      if (acc_mask[0]) rd[31:0]  = rnd_op();
      if (acc_mask[1]) rd[63:32] = rnd_op();
    end
    chk("stall_accepts", 32'(acc_n), 32'd4);
    chk("stall_req_ready", 32'(req_ready), 32'd0);
    chk("stall_busy", 32'(busy), 32'd1);
`ifdef FCVT_SCHED_PERF_EN
    chk("stall_perf_issue", perf_issue, 32'd4);
    chk("stall_perf_stall", perf_stall, 32'd6);
`endif
    rr = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cycle();
      if (acc_mask[0]) rd[31:0]  = rnd_op();
      if (acc_mask[1]) rd[63:32] = rnd_op();
    end
    drain();

    // Reset with conversions in flight
    rr = 1'b0;
    issue(0, rnd_op());
    issue(1, rnd_op());
    issue(0, rnd_op());
    rv = 2'b11;
    rstn = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    model_reset();
    cycle();
    rstn = 1'b1; rv = 2'b00; rr = 1'b1;
    seen_d.delete(); seen_id.delete();
    issue(0, 32'h0000_0001);
    drain();
    chk("post_rst_count", 32'(seen_d.size()), 32'd1);
    if (seen_d.size() == 1) chk("post_rst_data", seen_d[0], 32'h3F80_0000);

    // Random traffic with backpressure
    rv = 2'b00;
    for (int k = 0; k < 300; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!rv[i] || acc_mask[i]) begin
          rv[i] = ($urandom_range(0, 2) != 0);
          rd[32*i +: 32] = rnd_op();
        end
      end
      rr = ($urandom_range(0, 3) != 0);
      acc_mask = 2'b00;
      cycle();
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
